// File: rtl/fifo2wb_master_pkg.sv
// rtl/fifo2wb_master_pkg.sv - shared state encoding and Wishbone cycle constants
package fifo2wb_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_RETRY = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Byte address of a buffer word: one 32-bit word per index.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/fifo2wb_master_buf_idx_ctr.sv
// rtl/fifo2wb_master_buf_idx_ctr.sv - modulo buffer word index with half/wrap pulses
module fifo2wb_master_buf_idx_ctr #(
  parameter int BUF_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         inc,
  output logic [$clog2(BUF_WORDS)-1:0] idx,
  output logic                         half,
  output logic                         wrap
);

  localparam int IW = $clog2(BUF_WORDS);
  localparam logic [IW-1:0] HALF_IDX = IW'(BUF_WORDS / 2 - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BUF_WORDS - 1);

  // Pulses follow the index that was just acknowledged, even when the
  // same acknowledge also restarts the index at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      half <= 1'b0;
      wrap <= 1'b0;
    end else begin
      half <= inc && (idx == HALF_IDX);
      wrap <= inc && (idx == LAST_IDX);
      if (clear) begin
        idx <= '0;
      end else if (inc) begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/fifo2wb_master.sv
// rtl/fifo2wb_master.sv - drains the sample FIFO into a circular buffer via Wishbone writes
module fifo2wb_master
  import fifo2wb_master_pkg::*;
#(
  parameter int          FT_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          BUF_WORDS     = 1024
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [FT_DATA_WIDTH-1:0]     fifo_data_i,
  input  logic                         fifo_empty_i,
  output logic                         fifo_rd_o,
  output logic [31:0]                  wbm_adr_o,
  output logic [31:0]                  wbm_dat_o,
  output logic                         wbm_we_o,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic [3:0]                   wbm_sel_o,
  output logic [2:0]                   wbm_cti_o,
  output logic [1:0]                   wbm_bte_o,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i,
  input  logic                         wbm_rty_i,
  output logic [$clog2(BUF_WORDS)-1:0] idx_o,
  output logic                         half_o,
  output logic                         wrap_o,
  output logic                         err_o
);

  state_t state;
  state_t state_nxt;
  logic   clear_pend;
  logic   ack_done;
  logic   err_done;
  logic   ctr_clear;

  assign wbm_sel_o = 4'hF;
  assign wbm_cti_o = CTI_CLASSIC;
  assign wbm_bte_o = BTE_LINEAR;

  // err wins over ack, ack wins over rty
  assign err_done  = (state == ST_WRITE) && wbm_err_i;
  assign ack_done  = (state == ST_WRITE) && !wbm_err_i && wbm_ack_i;
  assign ctr_clear = (clear_i && ((state == ST_IDLE) || (state == ST_ERROR)))
                   || (ack_done && (clear_pend || clear_i));

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable_i && !fifo_empty_i && !err_o) state_nxt = ST_POP;
      ST_POP:   state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (wbm_err_i)      state_nxt = ST_ERROR;
        else if (wbm_ack_i) state_nxt = ST_IDLE;
        else if (wbm_rty_i) state_nxt = ST_RETRY;
      end
      ST_RETRY: state_nxt = ST_WRITE;
      ST_ERROR: if (clear_i) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Bus and pop strobes come straight from flops loaded with the next state
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      fifo_rd_o <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
    end else begin
      fifo_rd_o <= (state_nxt == ST_POP);
      wbm_cyc_o <= (state_nxt == ST_WRITE);
      wbm_stb_o <= (state_nxt == ST_WRITE);
      wbm_we_o  <= (state_nxt == ST_WRITE);
    end
  end

  // Address and data captured once per word, held through waits and retries
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else if (state == ST_LATCH) begin
      wbm_adr_o <= word_addr(BASE_ADDR, 32'(idx_o));
      wbm_dat_o <= fifo_data_i;
    end
  end

  // A clear that lands mid-word is remembered until that word finishes
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      clear_pend <= 1'b0;
    end else if ((state == ST_IDLE) || (state == ST_ERROR) || ack_done || err_done) begin
      clear_pend <= 1'b0;
    end else if (clear_i) begin
      clear_pend <= 1'b1;
    end
  end

  // Sticky bus-error flag
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      err_o <= 1'b0;
    end else if (err_done) begin
      err_o <= 1'b1;
    end else if (clear_i) begin
      err_o <= 1'b0;
    end
  end

  fifo2wb_master_buf_idx_ctr #(
    .BUF_WORDS (BUF_WORDS)
  ) u_idx_ctr (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .clear (ctr_clear),
    .inc   (ack_done),
    .idx   (idx_o),
    .half  (half_o),
    .wrap  (wrap_o)
  );

endmodule

// File: doc/fifo2wb_master.md
# fifo2wb_master

Wishbone master that drains the sample FIFO and writes each word into a circular memory buffer over Wishbone classic single writes. It is the initiator counterpart of the existing FIFO-facing Wishbone slave: the slave answers CPU accesses, while this block pushes SDR data onto the bus without CPU involvement. It signals half-buffer and buffer-wrap events so software can consume one half while the other fills.

## Interface
- FT_DATA_WIDTH, 32: FIFO word width; must be 32 (one Wishbone word per FIFO word).
- BASE_ADDR, 32'h0000_0000: byte address of buffer word 0; bits [1:0] are zero.
- BUF_WORDS, 1024: buffer length in words; power of two, at least 4.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  level; 1 allows new transfers to start.
- clear_i  in  1  one-cycle pulse; clears the word index and err_o.
- fifo_data_i  in  FT_DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_o.
- fifo_empty_i  in  1  FIFO empty.
- fifo_rd_o  out  1  FIFO pop strobe, one cycle wide.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1 each  bus controls.
- wbm_sel_o  out  4  byte selects; always 4'hF during a cycle.
- wbm_cti_o  out  3  cycle type; constant 3'b000 (classic).
- wbm_bte_o  out  2  burst type; constant 2'b00.
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  slave termination.
- idx_o  out  log2(BUF_WORDS)  index of the next word to be written.
- half_o  out  1  one-cycle pulse after the word at index BUF_WORDS/2-1 is acknowledged.
- wrap_o  out  1  one-cycle pulse after the word at index BUF_WORDS-1 is acknowledged.
- err_o  out  1  sticky flag for a bus error.

## Operation
- States: IDLE, POP, LATCH, WRITE, RETRY, ERROR.
- IDLE: when enable_i=1, fifo_empty_i=0 and err_o=0, go to POP.
- POP: fifo_rd_o=1 for exactly one cycle, then go to LATCH.
- LATCH: register fifo_data_i into wbm_dat_o and set wbm_adr_o = BASE_ADDR + (idx<<2), then go to WRITE.
- WRITE: wbm_cyc_o, wbm_stb_o and wbm_we_o are all 1 and held until a termination arrives.
  - ack: drop cyc/stb/we the next cycle, increment idx modulo BUF_WORDS, go to IDLE.
  - rty: go to RETRY. Hold cyc/stb low for one cycle, then return to WRITE with the same address and data; idx is unchanged.
  - err: go to ERROR, set err_o, leave idx unchanged, drop the word.
  - Simultaneous terminations: priority is err > ack > rty.
- ERROR: bus idle and no FIFO pops. clear_i returns the block to IDLE and clears err_o and idx.
- clear_i outside ERROR:
  - In IDLE: clears idx immediately.
  - In POP, LATCH, WRITE or RETRY: the in-flight word completes at its latched address, then idx is set to 0 instead of incrementing.
- enable_i deasserted mid-operation: the current word completes through ack; the block then waits in IDLE.
- half_o and wrap_o are registered and aligned with the idx update.

## Timing
- Reset values: all outputs 0 except wbm_sel_o=4'hF; idx=0; state IDLE.
- Reset asserted mid-cycle: cyc/stb drop asynchronously and the word is lost.
- Minimum throughput is 4 cycles per word with a zero-wait slave (ack in the cycle after stb rises): IDLE → POP → LATCH → WRITE, with ack seen on the WRITE cycle.
- wbm_adr_o and wbm_dat_o are stable for the whole WRITE phase, including retries.
- Outputs are registered, with no combinational path from wbm_ack_i to outputs.
- fifo_empty_i is sampled only in IDLE. The FIFO is never popped while empty.

## Structure
- A shared include file holds the state encoding and the Wishbone CTI/BTE constants (CTI_CLASSIC, BTE_LINEAR). The existing slave uses the same file.
- One natural sub-module, buf_idx_ctr: the modulo-BUF_WORDS counter with clear and the half/wrap pulse generation.
- Estimated size: 150–250 lines of RTL.

## Test plan
- **Single word.** BUF_WORDS=8, BASE_ADDR=32'h1000; FIFO holds 32'hA5A5_0001; zero-wait slave. Required: one write to 32'h1000 with that data, exactly one fifo_rd_o pulse, idx_o=1.
- **Wrap.** Stream 9 words 1..9. Required:
  - Addresses 32'h1000..32'h101C, then 32'h1000 again.
  - half_o after word 4, wrap_o after word 8, final idx_o=1.
- **Retry.** Slave answers rty twice, then ack. Required:
  - Three stb assertions, each separated by one low cycle, all with the same adr/dat.
  - One FIFO pop; idx advances once.
- **Error.** Slave answers err on word 3. Required:
  - err_o=1, bus idle, no further pops with FIFO non-empty.
  - After clear_i: idx_o=0 and transfers resume at 32'h1000.
- **Enable drop and wait states.** Drop enable_i during WRITE with 5 wait states. Required: the word completes, no further pop until enable_i=1.
- **Reset during WRITE.** Assert wb_rst_i during WRITE. Required: cyc/stb go to 0 without waiting for a clock edge; idx_o=0.
